wb_sdram_wbuf: RTL and testbench
================================

# wb_sdram_wbuf

Posted-write buffer and read sequencer sitting directly upstream of the SDRAM Wishbone bridge. The CPU-side Wishbone slave port acks writes in one cycle by queuing them in a small FIFO. The SDRAM-side Wishbone master port drains queued writes in order, one transfer at a time, with a mandatory idle gap between transfers. Reads are held until the FIFO has fully drained, then passed through, which preserves read-after-write ordering.

## Interface
Parameters:
- DEPTH, 4, number of write-buffer entries; power of two, 2..16.

Ports:
- wb_clk_i  in  1  the only clock; both ports and the FIFO run on it.
- wb_rst_i  in  1  reset, synchronous, active-high.
- s_cyc_i, s_stb_i  in  1  slave request qualifiers.
- s_we_i  in  1  1 = write, 0 = read.
- s_addr_i  in  32  byte address.
- s_sel_i  in  4  byte lane enables.
- s_data_i  in  32  write data.
- s_data_o  out  32  read data; valid while s_ack_o = 1 for a read.
- s_ack_o  out  1  single-cycle acknowledge.
- m_cyc_o, m_stb_o  out  1  master request, always driven together.
- m_we_o  out  1  master write enable.
- m_addr_o  out  32  master address.
- m_sel_o  out  4  master byte enables.
- m_data_o  out  32  master write data.
- m_data_i  in  32  master read data.
- m_ack_i  in  1  master acknowledge.
- wbuf_empty_o  out  1  1 when the FIFO holds no entries.
- wbuf_level_o  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Request: req = s_cyc_i & s_stb_i. No request is accepted in a cycle where s_ack_o = 1, so a held stb is never double-counted.
- Write accept:
  - If req & s_we_i and level < DEPTH, push {addr, sel, data}.
  - s_ack_o = 1 in the next cycle.
  - If the FIFO is full, no ack is given; the write waits until an entry frees.
- Read accept:
  - If req & ~s_we_i, a pending-read flag is set and the address and sel are latched.
  - The read waits until the FIFO is empty and the master FSM is in M_IDLE.
- Master FSM states: M_IDLE, M_WRITE, M_READ, M_GAP.
  - M_IDLE: if the FIFO is not empty, load the head entry into the m_* registers with m_we_o = 1 and go to M_WRITE. Otherwise, if a read is pending, load the read with m_we_o = 0 and go to M_READ. Writes always take priority.
  - M_WRITE: hold all m_* outputs stable. On m_ack_i: pop the head entry and go to M_GAP.
  - M_READ: hold all m_* outputs stable. On m_ack_i: capture m_data_i into s_data_o, pulse s_ack_o in the next cycle, clear pending-read, and go to M_GAP.
  - M_GAP: m_cyc_o = m_stb_o = 0 for exactly one cycle, then go to M_IDLE. The gap is required because the downstream bridge detects requests on the rising edge of stb.
- Simultaneous push and pop: level is unchanged and pointers wrap modulo DEPTH.
- Read abort:
  - If req drops before the read is issued, the read is cancelled.
  - If req drops after the read is issued, the master transfer completes, the data is discarded, and no s_ack_o is given.
- Writes are never aborted once acked.
- m_ack_i outside M_WRITE/M_READ is ignored.
- Reset (any cycle, including mid-transfer):
  - Next cycle: FIFO empty; FSM in M_IDLE; pending-read cleared.
  - All outputs 0 except wbuf_empty_o = 1.
  - Any in-flight master transfer is dropped (m_cyc_o = 0).

## Timing
- Write ack latency: request sampled in cycle N (not full) → s_ack_o = 1 in N+1.
- Drain latency: entry present and FSM in M_IDLE in cycle N → m_stb_o = 1 in N+1. Next transfer starts no earlier than 2 cycles after m_ack_i (one M_GAP cycle, then M_IDLE).
- Read latency: request sampled in cycle N with FIFO empty and M_IDLE → m_stb_o in N+1. If m_ack_i arrives in cycle M → s_data_o valid and s_ack_o = 1 in M+1.
- wbuf_level_o and wbuf_empty_o are registered and update in the cycle after a push or pop.
- s_ack_o is never high for two consecutive cycles.

## Test plan
- Single write: write addr 0x100, data 0xDEADBEEF, sel 0xF.
  - s_ack_o pulses 1 cycle later; level goes 1 then 0.
  - m_* carries the same addr/data/sel with m_we_o = 1.
- Fill and stall (DEPTH=4): 6 back-to-back writes with m_ack_i held low.
  - 4 acks, then no ack; wbuf_level_o = 4.
  - Release m_ack_i: the remaining 2 writes are acked as entries pop; all 6 appear on the master port in order.
- Read after write: write 0x200 ← 0x12345678, then immediately read 0x200.
  - Master issues the write, one gap cycle, then the read.
  - s_data_o = m_data_i, with s_ack_o one cycle after m_ack_i.
- Gap check: 3 queued writes with m_ack_i asserted every cycle the master requests.
  - m_stb_o goes low for exactly 1 cycle between transfers.
- Simultaneous push/pop: with level = 2, a write is accepted in the same cycle m_ack_i pops the head.
  - Level stays 2; data order is preserved across pointer wrap.
- Reset mid-read: assert wb_rst_i while in M_READ.
  - Next cycle: m_cyc_o = 0, s_ack_o = 0, wbuf_empty_o = 1.
  - A later m_ack_i produces no s_ack_o.

Source files
------------

// File: rtl/wb_sdram_wbuf.sv
// Posted-write buffer and read sequencer ahead of the SDRAM Wishbone bridge.
// Writes are acked as soon as they are queued; reads wait for the queue to drain.
module wb_sdram_wbuf #(
    parameter int DEPTH = 4
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       s_cyc_i,
    input  logic                       s_stb_i,
    input  logic                       s_we_i,
    input  logic [31:0]                s_addr_i,
    input  logic [3:0]                 s_sel_i,
    input  logic [31:0]                s_data_i,
    output logic [31:0]                s_data_o,
    output logic                       s_ack_o,
    output logic                       m_cyc_o,
    output logic                       m_stb_o,
    output logic                       m_we_o,
    output logic [31:0]                m_addr_o,
    output logic [3:0]                 m_sel_o,
    output logic [31:0]                m_data_o,
    input  logic [31:0]                m_data_i,
    input  logic                       m_ack_i,
    output logic                       wbuf_empty_o,
    output logic [$clog2(DEPTH):0]     wbuf_level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] L_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ, M_GAP} mstate_t;

    mstate_t r_state, w_next;

    logic [31:0]   r_fifo_addr [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [3:0]    r_fifo_sel  [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0] r_level, w_level_nxt;
    logic          r_empty;

    logic          r_ack;
    logic          r_rd_pend;
    logic [31:0]   r_rd_addr;
    logic [3:0]    r_rd_sel;
    logic [31:0]   r_s_data;

    logic          r_m_cyc, r_m_we;
    logic [31:0]   r_m_addr, r_m_data;
    logic [3:0]    r_m_sel;

    logic w_req, w_rd_hold, w_push, w_rd_new, w_rd_go;
    logic w_load_wr, w_load_rd, w_pop, w_rd_done;

    // A request is masked while its ack is on the bus so a held stb is not counted twice.
    assign w_req     = s_cyc_i & s_stb_i & ~r_ack;
    assign w_rd_hold = s_cyc_i & s_stb_i & ~s_we_i;
    assign w_push    = w_req & s_we_i & (r_level != L_FULL);
    // No new read is latched while an abandoned read is still finishing on the master side.
    assign w_rd_new  = w_req & ~s_we_i & ~r_rd_pend & (r_state != M_READ);
    assign w_rd_go   = (r_rd_pend & w_rd_hold) | w_rd_new;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= M_IDLE;
        else          r_state <= w_next;
    end

    // The gap cycle dispatches like idle, so stb is low for exactly that one cycle.
    always_comb begin
        w_next    = r_state;
        w_load_wr = 1'b0;
        w_load_rd = 1'b0;
        w_pop     = 1'b0;
        w_rd_done = 1'b0;
        case (r_state)
            M_IDLE, M_GAP: begin
                if (!r_empty) begin
                    w_load_wr = 1'b1;
                    w_next    = M_WRITE;
                end else if (w_rd_go) begin
                    w_load_rd = 1'b1;
                    w_next    = M_READ;
                end else begin
                    w_next    = M_IDLE;
                end
            end
            M_WRITE: begin
                if (m_ack_i) begin
                    w_pop  = 1'b1;
                    w_next = M_GAP;
                end
            end
            M_READ: begin
                if (m_ack_i) begin
                    w_rd_done = 1'b1;
                    w_next    = M_GAP;
                end
            end
            default: w_next = M_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= s_addr_i;
            r_fifo_data[r_wr_ptr] <= s_data_i;
            r_fifo_sel[r_wr_ptr]  <= s_sel_i;
        end
    end

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= w_level_nxt;
            r_empty <= (w_level_nxt == '0);
        end
    end

    // Pending read doubles as the "requester still waiting" flag for an issued read.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rd_pend <= 1'b0;
            r_rd_addr <= '0;
            r_rd_sel  <= '0;
        end else begin
            if (w_rd_done || !w_rd_hold) r_rd_pend <= 1'b0;
            else if (w_rd_new)           r_rd_pend <= 1'b1;
            if (w_rd_new) begin
                r_rd_addr <= s_addr_i;
                r_rd_sel  <= s_sel_i;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_s_data <= '0;
        end else begin
            r_ack <= w_push | (w_rd_done & r_rd_pend & w_rd_hold);
            if (w_rd_done) r_s_data <= m_data_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_m_cyc  <= 1'b0;
            r_m_we   <= 1'b0;
            r_m_addr <= '0;
            r_m_sel  <= '0;
            r_m_data <= '0;
        end else if (w_load_wr) begin
            r_m_cyc  <= 1'b1;
            r_m_we   <= 1'b1;
            r_m_addr <= r_fifo_addr[r_rd_ptr];
            r_m_sel  <= r_fifo_sel[r_rd_ptr];
            r_m_data <= r_fifo_data[r_rd_ptr];
        end else if (w_load_rd) begin
            r_m_cyc  <= 1'b1;
            r_m_we   <= 1'b0;
            r_m_addr <= r_rd_pend ? r_rd_addr : s_addr_i;
            r_m_sel  <= r_rd_pend ? r_rd_sel  : s_sel_i;
            r_m_data <= '0;
        end else if (w_pop || w_rd_done) begin
            r_m_cyc  <= 1'b0;
        end
    end

    assign s_ack_o      = r_ack;
    assign s_data_o     = r_s_data;
    assign m_cyc_o      = r_m_cyc;
    assign m_stb_o      = r_m_cyc;
    assign m_we_o       = r_m_we;
    assign m_addr_o     = r_m_addr;
    assign m_sel_o      = r_m_sel;
    assign m_data_o     = r_m_data;
    assign wbuf_empty_o = r_empty;
    assign wbuf_level_o = r_level;

endmodule

// File: tb/tb_wb_sdram_wbuf.sv
// Directed bench for wb_sdram_wbuf: CPU-side stimulus plus a simple SDRAM-side responder
// that logs every acked master transfer for ordering and gap checks.
module tb_wb_sdram_wbuf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
    logic [31:0] s_addr = '0, s_wdata = '0;
    logic [3:0]  s_sel = '0;
    logic [31:0] s_rdata;
    logic        s_ack;
    logic        m_cyc, m_stb, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_sel;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        empty;
    logic [2:0]  level;

    wb_sdram_wbuf #(.DEPTH(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_we_i(s_we), .s_addr_i(s_addr),
        .s_sel_i(s_sel), .s_data_i(s_wdata), .s_data_o(s_rdata), .s_ack_o(s_ack),
        .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_addr_o(m_addr),
        .m_sel_o(m_sel), .m_data_o(m_wdata), .m_data_i(m_rdata), .m_ack_i(m_ack),
        .wbuf_empty_o(empty), .wbuf_level_o(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        int          cyc;
        int          gap;
    } xfer_t;

    xfer_t log_q[$];
    int    cyc_n = 0;
    logic  ack_en = 1'b1;
    logic  ack_force = 1'b0;
    int    n_chk = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Responder acts at +2 after each edge; the main thread acts at +1.
    initial begin
        int low_cnt;
        low_cnt = 100;
        m_ack   = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            cyc_n++;
            #2;
            if (!m_cyc) low_cnt++;
            m_rdata = m_addr ^ 32'hC0DE_0000;
            m_ack   = (ack_en & m_cyc) | ack_force;
            if (ack_en && m_cyc) begin
                log_q.push_back('{m_we, m_addr, m_wdata, m_sel, cyc_n, low_cnt});
                low_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_start(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_addr = a; s_wdata = d; s_sel = s;
    endtask

    task automatic rd_start(input logic [31:0] a);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_addr = a; s_sel = 4'hF;
    endtask

    task automatic wait_ack(input int budget, output logic ok, output int at);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (s_ack) begin
                ok = 1'b1;
                at = cyc_n;
                break;
            end
        end
        if (ok) begin
            s_cyc = 1'b0;
            s_stb = 1'b0;
        end
    endtask

    task automatic wait_log(input int n, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (log_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        logic ok;
        int   at;
        int   acks;

        // reset
        step(); step();
        rst = 1'b0;
        chk("rst_ack", 32'(s_ack), 0);
        chk("rst_cyc", 32'(m_cyc), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_level", 32'(level), 0);
        chk("rst_sdata", s_rdata, 0);
        chk("rst_maddr", m_addr, 0);

        // single write
        wr_start(32'h100, 32'hDEADBEEF, 4'hF);
        step();
        chk("w1_ack", 32'(s_ack), 1);
        chk("w1_level1", 32'(level), 1);
        s_cyc = 1'b0; s_stb = 1'b0;
        step();
        chk("w1_ack_drop", 32'(s_ack), 0);
        chk("w1_stb", 32'(m_stb), 1);
        chk("w1_we", 32'(m_we), 1);
        chk("w1_addr", m_addr, 32'h100);
        chk("w1_data", m_wdata, 32'hDEADBEEF);
        chk("w1_sel", 32'(m_sel), 32'hF);
        step();
        chk("w1_stb_off", 32'(m_stb), 0);
        chk("w1_level0", 32'(level), 0);
        chk("w1_empty", 32'(empty), 1);
        chk("w1_log", 32'(log_q.size()), 1);
        step();

        // fill and stall
        log_q.delete();
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_start(32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF);
            wait_ack(8, ok, at);
            chk("fill_ack", 32'(ok), 1);
        end
        chk("fill_level", 32'(level), 4);
        wr_start(32'h1010, 32'hA000_0004, 4'hF);
        wait_ack(6, ok, at);
        chk("full_stall", 32'(ok), 0);
        chk("full_level", 32'(level), 4);
        ack_en = 1'b1;
        wait_ack(20, ok, at);
        chk("fill_ack4", 32'(ok), 1);
        wr_start(32'h1014, 32'hA000_0005, 4'hF);
        wait_ack(20, ok, at);
        chk("fill_ack5", 32'(ok), 1);
        wait_log(6, 60, ok);
        chk("fill_drain", 32'(ok), 1);
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            chk("fill_addr", log_q[i].addr, 32'h1000 + 32'(i * 4));
            chk("fill_data", log_q[i].data, 32'hA000_0000 + 32'(i));
        end
        step(); step();
        chk("fill_empty", 32'(empty), 1);

        // read after write
        log_q.delete();
        wr_start(32'h200, 32'h12345678, 4'hF);
        wait_ack(8, ok, at);
        chk("raw_wack", 32'(ok), 1);
        rd_start(32'h200);
        wait_ack(20, ok, at);
        chk("raw_rack", 32'(ok), 1);
        chk("raw_rdata", s_rdata, 32'hC0DE_0200);
        chk("raw_nlog", 32'(log_q.size()), 2);
        if (log_q.size() >= 2) begin
            chk("raw_w_we", 32'(log_q[0].we), 1);
            chk("raw_w_data", log_q[0].data, 32'h12345678);
            chk("raw_r_we", 32'(log_q[1].we), 0);
            chk("raw_r_addr", log_q[1].addr, 32'h200);
            chk("raw_gap", 32'(log_q[1].gap), 1);
            chk("raw_lat", 32'(at), 32'(log_q[1].cyc + 1));
        end
        step();
        chk("raw_ack_once", 32'(s_ack), 0);
        step();

        // gap between back-to-back writes
        log_q.delete();
        ack_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_start(32'h3000 + 32'(i * 4), 32'hB000_0000 + 32'(i), 4'h3);
            wait_ack(8, ok, at);
            chk("gap_wack", 32'(ok), 1);
        end
        ack_en = 1'b1;
        wait_log(3, 40, ok);
        chk("gap_drain", 32'(ok), 1);
        if (log_q.size() >= 3) begin
            for (int i = 1; i < 3; i++) begin
                chk("gap_low", 32'(log_q[i].gap), 1);
                chk("gap_dist", 32'(log_q[i].cyc - log_q[i-1].cyc), 2);
                chk("gap_sel", 32'(log_q[i].sel), 32'h3);
            end
        end
        step(); step();

        // simultaneous push and pop across pointer wrap
        log_q.delete();
        ack_en = 1'b0;
        wr_start(32'h4000, 32'hC000_0000, 4'hF);
        wait_ack(8, ok, at);
        wr_start(32'h4004, 32'hC000_0001, 4'hF);
        wait_ack(8, ok, at);
        step();
        chk("pp_level_pre", 32'(level), 2);
        wr_start(32'h4008, 32'hC000_0002, 4'hF);
        ack_en = 1'b1;
        step();
        chk("pp_ack", 32'(s_ack), 1);
        chk("pp_level", 32'(level), 2);
        s_cyc = 1'b0; s_stb = 1'b0;
        wr_start(32'h400C, 32'hC000_0003, 4'hF);
        wait_ack(8, ok, at);
        wr_start(32'h4010, 32'hC000_0004, 4'hF);
        wait_ack(8, ok, at);
        wait_log(5, 60, ok);
        chk("pp_drain", 32'(ok), 1);
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            chk("pp_addr", log_q[i].addr, 32'h4000 + 32'(i * 4));
            chk("pp_data", log_q[i].data, 32'hC000_0000 + 32'(i));
        end
        step(); step();

        // read abandoned after issue: transfer completes, no ack
        log_q.delete();
        ack_en = 1'b0;
        rd_start(32'h500);
        step();
        chk("ab_cyc", 32'(m_cyc), 1);
        chk("ab_we", 32'(m_we), 0);
        chk("ab_addr", m_addr, 32'h500);
        s_cyc = 1'b0; s_stb = 1'b0;
        step();
        ack_en = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (s_ack) acks++;
        end
        chk("ab_noack", 32'(acks), 0);
        chk("ab_log", 32'(log_q.size()), 1);
        chk("ab_idle", 32'(m_cyc), 0);

        // reset during a read
        ack_en = 1'b0;
        rd_start(32'h600);
        step();
        chk("rr_cyc", 32'(m_cyc), 1);
        chk("rr_we", 32'(m_we), 0);
        rst = 1'b1;
        s_cyc = 1'b0; s_stb = 1'b0;
        step();
        rst = 1'b0;
        chk("rr_cyc0", 32'(m_cyc), 0);
        chk("rr_ack0", 32'(s_ack), 0);
        chk("rr_empty", 32'(empty), 1);
        chk("rr_sdata", s_rdata, 0);
        ack_force = 1'b1;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (s_ack || m_cyc) acks++;
        end
        ack_force = 1'b0;
        step();
        chk("rr_late_ack", 32'(acks), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
